// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the single memory port.
// The slave modport is the arbiter's view; the master modport is the
// requester/memory environment's view.
interface mem_arbiter_if #(
    parameter int unsigned AW = 12
) ();
    // Requester 0
    logic          i_cyc0;
    logic          i_we0;
    logic [AW-1:0] i_addr0;
    logic [15:0]   i_dat0;
    logic          o_ack0;
    logic [15:0]   o_dat0;
    // Requester 1
    logic          i_cyc1;
    logic          i_we1;
    logic [AW-1:0] i_addr1;
    logic [15:0]   i_dat1;
    logic          o_ack1;
    logic [15:0]   o_dat1;
    // Memory side
    logic          o_mem_cyc;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [15:0]   o_mem_dat;
    logic [15:0]   i_mem_dat;

    modport slave (
        input  i_cyc0, i_we0, i_addr0, i_dat0,
        input  i_cyc1, i_we1, i_addr1, i_dat1,
        input  i_mem_dat,
        output o_ack0, o_dat0, o_ack1, o_dat1,
        output o_mem_cyc, o_mem_we, o_mem_addr, o_mem_dat
    );

    modport master (
        output i_cyc0, i_we0, i_addr0, i_dat0,
        output i_cyc1, i_we1, i_addr1, i_dat1,
        output i_mem_dat,
        input  o_ack0, o_dat0, o_ack1, o_dat1,
        input  o_mem_cyc, o_mem_we, o_mem_addr, o_mem_dat
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported 16-bit block memory.
// Each access takes two cycles (IDLE, then GNTn); the memory port and the
// granted requester's ack/data are driven combinationally from the GNTn state.
// Optional build macro MEM_ARBITER_RR_EN: round-robin tie-break using a
// last-grant bit; when undefined, port 0 always wins ties.
module mem_arbiter #(
    parameter int unsigned AW = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } state_e;

    state_e        state_q, state_d;
    logic          tie_pick1;
    logic [AW-1:0] mem_addr;

`ifdef MEM_ARBITER_RR_EN
    logic last_q, last_d;

    // Tie goes to the port that was not granted last.
    always_comb begin
        tie_pick1 = (last_q == 1'b0);
        last_d    = last_q;
        if (state_d == StGnt0) last_d = 1'b0;
        if (state_d == StGnt1) last_d = 1'b1;
    end

    // Last-grant register; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) last_q <= 1'b1;
        else         last_q <= last_d;
    end
`else
    // Fixed priority: port 0 always wins a tie.
    always_comb begin
        tie_pick1 = 1'b0;
    end
`endif

    // State register; reset forces IDLE even in the middle of a grant.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state: grants last exactly one cycle and always fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.i_cyc0 && bus.i_cyc1) state_d = tie_pick1 ? StGnt1 : StGnt0;
                else if (bus.i_cyc0)          state_d = StGnt0;
                else if (bus.i_cyc1)          state_d = StGnt1;
            end
            StGnt0:  state_d = StIdle;
            StGnt1:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: route the granted port to memory; everything else reads as 0.
    always_comb begin
        bus.o_mem_cyc = 1'b0;
        bus.o_mem_we  = 1'b0;
        mem_addr      = '0;
        bus.o_mem_dat = '0;
        bus.o_ack0    = 1'b0;
        bus.o_ack1    = 1'b0;
        bus.o_dat0    = '0;
        bus.o_dat1    = '0;
        case (state_q)
            StGnt0: begin
                bus.o_mem_cyc = 1'b1;
                bus.o_mem_we  = bus.i_we0;
                mem_addr      = bus.i_addr0;
                bus.o_mem_dat = bus.i_dat0;
                bus.o_ack0    = 1'b1;
                bus.o_dat0    = bus.i_mem_dat;
            end
            StGnt1: begin
                bus.o_mem_cyc = 1'b1;
                bus.o_mem_we  = bus.i_we1;
                mem_addr      = bus.i_addr1;
                bus.o_mem_dat = bus.i_dat1;
                bus.o_ack1    = 1'b1;
                bus.o_dat1    = bus.i_mem_dat;
            end
            default: ;
        endcase
    end

    assign bus.o_mem_addr = mem_addr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural block memory.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    logic mem_clr;
    int   checks;
    int   failures;

    logic [15:0] mem [0:4095];

    typedef struct packed {
        logic        ack_c1;
        logic        ack_c2;
        logic        other_ack;
        logic [15:0] other_dat;
        logic [15:0] rdat;
        logic        mcyc;
        logic        mwe;
        logic [11:0] maddr;
        logic [15:0] mdat;
    } obs_t;

    mem_arbiter_if #(.AW(12)) mif ();

    mem_arbiter #(.AW(12)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on rising edge when strobed.
    assign mif.i_mem_dat = mem[mif.o_mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'h3c3c;
        end else if (mif.o_mem_cyc && mif.o_mem_we) begin
            mem[mif.o_mem_addr] <= mif.o_mem_dat;
        end
    end

    // Single access on one port; returns what was observed in both cycles.
    task automatic access(input bit port, input logic we, input logic [11:0] addr,
                          input logic [15:0] dat, output obs_t o);
        @(posedge clk); #1;
        if (!port) begin
            mif.i_cyc0 = 1'b1; mif.i_we0 = we; mif.i_addr0 = addr; mif.i_dat0 = dat;
        end else begin
            mif.i_cyc1 = 1'b1; mif.i_we1 = we; mif.i_addr1 = addr; mif.i_dat1 = dat;
        end
        @(negedge clk);
        o.ack_c1 = port ? mif.o_ack1 : mif.o_ack0;
        @(negedge clk);
        o.ack_c2    = port ? mif.o_ack1 : mif.o_ack0;
        o.other_ack = port ? mif.o_ack0 : mif.o_ack1;
        o.other_dat = port ? mif.o_dat0 : mif.o_dat1;
        o.rdat      = port ? mif.o_dat1 : mif.o_dat0;
        o.mcyc      = mif.o_mem_cyc;
        o.mwe       = mif.o_mem_we;
        o.maddr     = mif.o_mem_addr;
        o.mdat      = mif.o_mem_dat;
        @(posedge clk); #1;
        mif.i_cyc0 = 1'b0; mif.i_we0 = 1'b0;
        mif.i_cyc1 = 1'b0; mif.i_we1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        mif.i_cyc0 = 1'b1; mif.i_addr0 = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mif.o_ack0 !== 1'b0 || mif.o_ack1 !== 1'b0) begin
            failures++; $display("FAIL reset_acks: got %b%b required 00", mif.o_ack0, mif.o_ack1);
        end
        checks++; if (mif.o_mem_cyc !== 1'b0 || mif.o_mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_mem_strobes: got %b%b required 00",
                                 mif.o_mem_cyc, mif.o_mem_we);
        end
        checks++; if (mif.o_mem_addr !== 12'h000 || mif.o_mem_dat !== 16'h0000) begin
            failures++; $display("FAIL reset_mem_bus: got %h/%h required 000/0000",
                                 mif.o_mem_addr, mif.o_mem_dat);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        checks++; if (mif.o_ack0 !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle: got ack0=%b required 0", mif.o_ack0);
        end
        @(negedge clk);
        checks++; if (mif.o_ack0 !== 1'b1 || mif.o_dat0 !== 16'h3c3c) begin
            failures++; $display("FAIL post_reset_grant: got ack0=%b dat0=%h required 1/3c3c",
                                 mif.o_ack0, mif.o_dat0);
        end
        @(posedge clk); #1;
        mif.i_cyc0 = 1'b0;
    endtask

    task automatic test_write_read();
        obs_t o;
        access(1'b0, 1'b1, 12'h005, 16'h1234, o);
        checks++; if (o.ack_c1 !== 1'b0 || o.ack_c2 !== 1'b1) begin
            failures++; $display("FAIL wr_ack_timing: got c1=%b c2=%b required 0/1", o.ack_c1, o.ack_c2);
        end
        checks++; if (o.mcyc !== 1'b1 || o.mwe !== 1'b1 || o.maddr !== 12'h005 || o.mdat !== 16'h1234) begin
            failures++; $display("FAIL wr_mem_port: got cyc=%b we=%b a=%h d=%h required 1/1/005/1234",
                                 o.mcyc, o.mwe, o.maddr, o.mdat);
        end
        checks++; if (o.other_ack !== 1'b0 || o.other_dat !== 16'h0000) begin
            failures++; $display("FAIL wr_other_port: got ack1=%b dat1=%h required 0/0000",
                                 o.other_ack, o.other_dat);
        end
        access(1'b0, 1'b0, 12'h005, 16'h0000, o);
        checks++; if (o.ack_c2 !== 1'b1 || o.rdat !== 16'h1234 || o.mwe !== 1'b0) begin
            failures++; $display("FAIL rd_back: got ack=%b dat=%h we=%b required 1/1234/0",
                                 o.ack_c2, o.rdat, o.mwe);
        end
    endtask

    task automatic test_tie_after_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        mif.i_cyc0 = 1'b1; mif.i_we0 = 1'b0; mif.i_addr0 = 12'h010;
        mif.i_cyc1 = 1'b1; mif.i_we1 = 1'b1; mif.i_addr1 = 12'h010; mif.i_dat1 = 16'hBEEF;
        @(negedge clk);
        checks++; if (mif.o_ack0 !== 1'b0 || mif.o_ack1 !== 1'b0) begin
            failures++; $display("FAIL tie_c1: got %b%b required 00", mif.o_ack0, mif.o_ack1);
        end
        @(negedge clk);
        checks++; if (mif.o_ack0 !== 1'b1 || mif.o_ack1 !== 1'b0 || mif.o_dat0 !== 16'h3c2c) begin
            failures++; $display("FAIL tie_c2_port0: got ack0=%b ack1=%b dat0=%h required 1/0/3c2c",
                                 mif.o_ack0, mif.o_ack1, mif.o_dat0);
        end
        @(posedge clk); #1; mif.i_cyc0 = 1'b0;
        @(negedge clk);
        checks++; if (mif.o_ack1 !== 1'b0 || mif.o_mem_cyc !== 1'b0) begin
            failures++; $display("FAIL tie_c3_idle: got ack1=%b cyc=%b required 0/0",
                                 mif.o_ack1, mif.o_mem_cyc);
        end
        @(negedge clk);
        checks++; if (mif.o_ack1 !== 1'b1 || mif.o_mem_we !== 1'b1 || mif.o_mem_addr !== 12'h010 ||
                      mif.o_mem_dat !== 16'hBEEF) begin
            failures++; $display("FAIL tie_c4_port1: got ack1=%b we=%b a=%h d=%h required 1/1/010/beef",
                                 mif.o_ack1, mif.o_mem_we, mif.o_mem_addr, mif.o_mem_dat);
        end
        @(posedge clk); #1; mif.i_cyc1 = 1'b0; mif.i_we1 = 1'b0;
        @(negedge clk);
        checks++; if (mem[16] !== 16'hBEEF) begin
            failures++; $display("FAIL tie_write_landed: got %h required beef", mem[16]);
        end
    endtask

    task automatic test_sustained_tie();
        logic [7:0] exp0, exp1;
`ifdef MEM_ARBITER_RR_EN
        exp0 = 8'b0010_0010;
        exp1 = 8'b1000_1000;
`else
        exp0 = 8'b1010_1010;
        exp1 = 8'b0000_0000;
`endif
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        mif.i_cyc0 = 1'b1; mif.i_we0 = 1'b0; mif.i_addr0 = 12'h001;
        mif.i_cyc1 = 1'b1; mif.i_we1 = 1'b0; mif.i_addr1 = 12'h002;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (mif.o_ack0 !== exp0[c] || mif.o_ack1 !== exp1[c]) begin
                failures++; $display("FAIL sustained_c%0d: got ack0=%b ack1=%b required %b/%b",
                                     c + 1, mif.o_ack0, mif.o_ack1, exp0[c], exp1[c]);
            end
        end
        @(posedge clk); #1; mif.i_cyc0 = 1'b0; mif.i_cyc1 = 1'b0;
    endtask

    task automatic test_reset_during_grant();
        @(posedge clk); #1;
        mif.i_cyc1 = 1'b1; mif.i_we1 = 1'b0; mif.i_addr1 = 12'h020;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mif.o_ack1 !== 1'b1) begin
            failures++; $display("FAIL rdg_grant: got ack1=%b required 1", mif.o_ack1);
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (mif.o_ack1 !== 1'b0 || mif.o_mem_cyc !== 1'b0) begin
                failures++; $display("FAIL rdg_in_reset_%0d: got ack1=%b cyc=%b required 0/0",
                                     c, mif.o_ack1, mif.o_mem_cyc);
            end
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (mif.o_ack1 !== 1'b0) begin
            failures++; $display("FAIL rdg_idle_after: got ack1=%b required 0", mif.o_ack1);
        end
        @(negedge clk);
        checks++; if (mif.o_ack1 !== 1'b1 || mif.o_dat1 !== 16'h3c1c) begin
            failures++; $display("FAIL rdg_reserved: got ack1=%b dat1=%h required 1/3c1c",
                                 mif.o_ack1, mif.o_dat1);
        end
        @(posedge clk); #1; mif.i_cyc1 = 1'b0;
    endtask

    task automatic test_boundary();
        obs_t o;
        access(1'b0, 1'b1, 12'hFFF, 16'hA5A5, o);
        checks++; if (o.ack_c2 !== 1'b1 || o.maddr !== 12'hFFF || o.mdat !== 16'hA5A5) begin
            failures++; $display("FAIL bnd_write: got ack=%b a=%h d=%h required 1/fff/a5a5",
                                 o.ack_c2, o.maddr, o.mdat);
        end
        access(1'b1, 1'b0, 12'hFFF, 16'h0000, o);
        checks++; if (o.ack_c2 !== 1'b1 || o.rdat !== 16'hA5A5 || o.other_ack !== 1'b0) begin
            failures++; $display("FAIL bnd_read_top: got ack1=%b dat1=%h ack0=%b required 1/a5a5/0",
                                 o.ack_c2, o.rdat, o.other_ack);
        end
        access(1'b0, 1'b0, 12'h000, 16'h0000, o);
        checks++; if (o.ack_c2 !== 1'b1 || o.rdat !== 16'h3c3c) begin
            failures++; $display("FAIL bnd_read_zero: got ack0=%b dat0=%h required 1/3c3c",
                                 o.ack_c2, o.rdat);
        end
    endtask

    task automatic test_cancel();
        @(posedge clk); #1;
        mif.i_cyc0 = 1'b1; mif.i_we0 = 1'b1; mif.i_addr0 = 12'h033; mif.i_dat0 = 16'hDEAD;
        @(negedge clk);
        mif.i_cyc0 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (mif.o_ack0 !== 1'b0 || mif.o_mem_cyc !== 1'b0) begin
                failures++; $display("FAIL cancel_%0d: got ack0=%b cyc=%b required 0/0",
                                     c, mif.o_ack0, mif.o_mem_cyc);
            end
        end
        checks++; if (mem[51] !== (16'h0033 ^ 16'h3c3c)) begin
            failures++; $display("FAIL cancel_no_write: got %h required %h", mem[51],
                                 16'h0033 ^ 16'h3c3c);
        end
        mif.i_we0 = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; mem_clr = 1'b1;
        mif.i_cyc0 = 1'b0; mif.i_we0 = 1'b0; mif.i_addr0 = '0; mif.i_dat0 = '0;
        mif.i_cyc1 = 1'b0; mif.i_we1 = 1'b0; mif.i_addr1 = '0; mif.i_dat1 = '0;
        test_reset();
        test_write_read();
        test_tie_after_reset();
        test_sustained_tie();
        test_reset_during_grant();
        test_boundary();
        test_cancel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
